serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Parametrised multi-cycle adder/subtractor that processes DIGIT bits per clock through a registered carry, trading latency for area. It is the sequential successor to the single-bit full adder. It adds WIDTH-bit operands with carry-in, supports subtract mode, and reports carry-out and signed overflow. It uses a start/busy/done handshake so a controller or testbench can issue back-to-back operations.

Parameters:
WIDTH, 8, operand and result width in bits; must be at least 1.
DIGIT, 1, bits processed per cycle; WIDTH % DIGIT must be 0, otherwise elaboration fails with $error/$fatal.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only while busy=0.
sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1 with cin ignored.
a  input  WIDTH  operand A, captured on accepted start.
b  input  WIDTH  operand B, captured on accepted start.
cin  input  1  carry-in, captured on accepted start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when the result registers update.
sum  output  WIDTH  result; held until the next completion.
cout  output  1  carry-out of the MSB; for sub, 1 means no borrow.
ovf  output  1  signed overflow of the operation.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; carry, shift and count registers all 0. No done pulse is produced for an aborted operation.
- Let N = WIDTH/DIGIT. FSM states:
  - IDLE: start=1 at a rising edge accepts the request.
    - Latch a into shift register A.
    - Latch b_eff into shift register B: b_eff = sub ? ~b : b.
    - Initialise the carry register to sub ? 1 : cin.
    - Record sign bits a[WIDTH-1] and b_eff[WIDTH-1].
    - Set count=0 and go to RUN; busy=1 from the next cycle.
  - RUN: each edge adds the low DIGIT bits of A and B plus carry.
    - Shift the DIGIT-bit result into the top of the result shift register.
    - Update carry; shift A and B right by DIGIT; increment count.
    - On the edge where count==N-1 (the Nth RUN edge), load sum from the completed result shift register and cout from the final carry.
    - On the same edge set ovf = (sa==sb) && (sum_msb!=sa), set done=1 and busy=0, and return to IDLE.
- Latency: accepted start at edge k gives done=1 and valid sum during the cycle after edge k+N. DIGIT=WIDTH gives N=1, a single-cycle registered adder.
- done is high for exactly one cycle. start on that cycle (busy=0) is accepted, giving back-to-back operation with no dead cycle.
- start while busy=1 is ignored. Operands are not re-sampled and the operation in progress is unaffected.
- Inputs a, b, sub and cin may change freely after acceptance.
- sum, cout and ovf keep the previous result throughout RUN and change only on completion edges.
- Arithmetic is modulo 2^WIDTH. There are no X outputs after reset.

Decomposition:
- No shared package needed.
- The N and count width constants, with count width = $clog2(N) and a minimum of 1, are local parameters.
- One natural sub-module: digit_adder #(DIGIT), purely combinational.
  - Inputs: x[DIGIT-1:0], y[DIGIT-1:0], ci.
  - Outputs: s[DIGIT-1:0], co.
  - Built from a chain of full-adder cells.
- serial_adder holds the FSM, counter and shift/result registers.

Test Plan:
- WIDTH=8, DIGIT=1: a=200, b=100, cin=0, sub=0 -> after 8 cycles, done pulse; sum=44, cout=1, ovf=0; busy high for exactly 8 cycles.
- WIDTH=8, DIGIT=1: a=127, b=1, cin=0 -> sum=128, cout=0, ovf=1. Then sub=1, a=5, b=7 -> sum=8'hFE, cout=0, ovf=0.
- WIDTH=4, DIGIT=2: exhaustive a, b in 0..15, cin in {0,1}, sub in {0,1} against the model a+b+cin or a+~b+1 -> all sum/cout/ovf match; each done arrives 2 cycles after acceptance.
- Handshake: pulse start again mid-RUN with different operands -> ignored, first result unchanged. Assert start on the done cycle with a=3, b=4 -> accepted; next result 7 after N cycles with no idle gap.
- Reset mid-operation: assert rst during the 4th RUN cycle (WIDTH=8, DIGIT=1) -> immediately all outputs 0, busy=0; no done pulse follows. A new start after release gives a correct result.
- WIDTH=8, DIGIT=8: a=255, b=1, cin=1 -> done one cycle after acceptance; sum=1, cout=1, ovf=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Counter width for N digit steps, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 32'd1) ? int'($clog2(n)) : 32'd1;
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake plus operand and result bus of the serial adder.
interface serial_adder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic             sub;
   logic             cin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, cin, a, b,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, cin, a, b,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder built from a chain of full-adder cells.
module digit_adder #(
   parameter int unsigned DIGIT = 1
) (
   input  logic [DIGIT-1:0] i_x,
   input  logic [DIGIT-1:0] i_y,
   input  logic             i_ci,
   output logic [DIGIT-1:0] o_s,
   output logic             o_co
);
   logic [DIGIT:0] w_c;

   assign w_c[0] = i_ci;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign o_s[i]     = i_x[i] ^ i_y[i] ^ w_c[i];
      assign w_c[i + 1] = (i_x[i] & i_y[i]) | (w_c[i] & (i_x[i] ^ i_y[i]));
   end

   assign o_co = w_c[DIGIT];
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: consumes DIGIT bits per clock through a registered
// carry and publishes sum/cout/ovf with a one-cycle done pulse after N steps.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic           clk,
   input  logic           rst,
   serial_adder_if.slave  bus
);
   if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $fatal(1, "serial_adder: WIDTH must be a non-zero multiple of DIGIT");
   end

   localparam int unsigned N  = WIDTH / DIGIT;
   localparam int unsigned CW = cnt_width(N);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_accept;
   logic             w_step;
   logic             w_last;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_sum;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_sa;
   logic             r_sb;
   logic             r_cout;
   logic             r_ovf;
   logic             r_done;
   logic             r_busy;

   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH-1:0] w_res_nxt;
   logic [DIGIT-1:0] w_s;
   logic             w_co;

   assign w_b_eff = bus.sub ? ~bus.b : bus.b;

   digit_adder #(.DIGIT(DIGIT)) u_digit (
      .i_x  (r_a[DIGIT-1:0]),
      .i_y  (r_b[DIGIT-1:0]),
      .i_ci (r_carry),
      .o_s  (w_s),
      .o_co (w_co)
   );

   // New digit enters at the top; after N steps the LSB digit has reached bit 0.
   assign w_res_nxt = WIDTH'({w_s, r_res} >> DIGIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
         S_RUN:   if (w_last)    w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_accept = 1'b0;
      w_step   = 1'b0;
      w_last   = 1'b0;
      case (r_state)
         S_IDLE: w_accept = bus.start;
         S_RUN: begin
            w_step = 1'b1;
            w_last = (r_cnt == CW'(N - 1));
         end
         default: ;
      endcase
   end

   // Operand/result shifting; published results change only on the final step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_sa    <= 1'b0;
         r_sb    <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= w_b_eff;
            r_carry <= bus.sub ? 1'b1 : bus.cin;
            r_sa    <= bus.a[WIDTH-1];
            r_sb    <= w_b_eff[WIDTH-1];
            r_cnt   <= '0;
            r_busy  <= 1'b1;
         end else if (w_step) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_res   <= w_res_nxt;
            r_carry <= w_co;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
               r_sum  <= w_res_nxt;
               r_cout <= w_co;
               r_ovf  <= (r_sa == r_sb) && (w_res_nxt[WIDTH-1] != r_sa);
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end
         end
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;
   assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder in three shapes: 8x1, 4x2 and 8x8 bits.
module tb_serial_adder;

   typedef struct {
      logic [7:0]  sum;
      logic        cout;
      logic        ovf;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   serial_adder_if #(.WIDTH(8)) bus8 ();
   serial_adder_if #(.WIDTH(4)) bus4 ();
   serial_adder_if #(.WIDTH(8)) bus88 ();

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
   serial_adder #(.WIDTH(4), .DIGIT(2)) u_dut4  (.clk(clk), .rst(rst), .bus(bus4));
   serial_adder #(.WIDTH(8), .DIGIT(8)) u_dut88 (.clk(clk), .rst(rst), .bus(bus88));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] s, input logic co, input logic ov);
      exp_t e;
      e.sum = s; e.cout = co; e.ovf = ov; e.cyc = 0;
      return e;
   endfunction

   // Reference arithmetic on a w-bit word.
   function automatic exp_t model(input int unsigned w, input int unsigned a, input int unsigned b,
                                  input logic ci, input logic sb);
      exp_t        e;
      int unsigned mask = (32'd1 << w) - 1;
      int unsigned be   = sb ? (~b & mask) : b;
      int unsigned c    = sb ? 32'd1 : {31'd0, ci};
      int unsigned full = a + be + c;
      int unsigned s    = full & mask;
      e.sum  = 8'(s);
      e.cout = full[w];
      e.ovf  = (a[w-1] == be[w-1]) && (s[w-1] != a[w-1]);
      e.cyc  = 0;
      return e;
   endfunction

   function automatic int unsigned nof(input int id);
      return (id == 0) ? 32'd8 : (id == 1) ? 32'd2 : 32'd1;
   endfunction

   function automatic logic get_done(input int id);
      return (id == 0) ? bus8.done : (id == 1) ? bus4.done : bus88.done;
   endfunction

   task automatic drive(input int id, input logic st, input logic sb, input logic [7:0] a,
                        input logic [7:0] b, input logic ci);
      case (id)
         0: begin bus8.start = st; bus8.sub = sb; bus8.a = a; bus8.b = b; bus8.cin = ci; end
         1: begin bus4.start = st; bus4.sub = sb; bus4.a = 4'(a); bus4.b = 4'(b); bus4.cin = ci; end
         default: begin bus88.start = st; bus88.sub = sb; bus88.a = a; bus88.b = b; bus88.cin = ci; end
      endcase
   endtask

   task automatic push(input int id, input exp_t e);
      case (id)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Present a start for one cycle, then scramble the inputs once it is taken.
   task automatic issue(input int id, input logic sb, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input bit do_push, input exp_t e);
      @(negedge clk);
      drive(id, 1'b1, sb, a, b, ci);
      @(posedge clk);
      #1;
      if (do_push) begin
         e.cyc = cyc + nof(id);
         push(id, e);
      end
      drive(id, 1'b0, ~sb, ~a, ~b, ~ci);
   endtask

   task automatic wait_done(input int id, input string name);
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (get_done(id)) seen = 1;
      end
      if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic mon(input int id, input logic [7:0] s, input logic co, input logic ov);
      exp_t e;
      bit   have = 0;
      case (id)
         0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
         1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
      endcase
      if (!have) begin
         check($sformatf("unexpected_done_%0d", id), 32'd1, 32'd0);
      end else begin
         check($sformatf("sum_%0d", id),     {24'd0, s},  {24'd0, e.sum});
         check($sformatf("cout_%0d", id),    {31'd0, co}, {31'd0, e.cout});
         check($sformatf("ovf_%0d", id),     {31'd0, ov}, {31'd0, e.ovf});
         check($sformatf("latency_%0d", id), cyc,         e.cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus8.done)  mon(0, bus8.sum, bus8.cout, bus8.ovf);
         if (bus4.done)  mon(1, {4'd0, bus4.sum}, bus4.cout, bus4.ovf);
         if (bus88.done) mon(2, bus88.sum, bus88.cout, bus88.ovf);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt;
      drive(0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
      drive(1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
      drive(2, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
      repeat (2) @(negedge clk);
      check("reset_w8",  {21'd0, bus8.busy,  bus8.done,  bus8.cout,  bus8.ovf,  bus8.sum},  32'd0);
      check("reset_w4",  {25'd0, bus4.busy,  bus4.done,  bus4.cout,  bus4.ovf,  bus4.sum},  32'd0);
      check("reset_w88", {21'd0, bus88.busy, bus88.done, bus88.cout, bus88.ovf, bus88.sum}, 32'd0);
      rst = 1'b0;

      // 200 + 100 wraps to 44 with carry out; busy spans exactly N cycles.
      issue(0, 1'b0, 8'd200, 8'd100, 1'b0, 1, mk(8'd44, 1'b1, 1'b0));
      busy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus8.done) break;
         if (bus8.busy) busy_cnt++;
      end
      check("busy_cycles", busy_cnt, 32'd8);

      issue(0, 1'b0, 8'd127, 8'd1, 1'b0, 1, mk(8'd128, 1'b0, 1'b1));
      wait_done(0, "pos_ovf");
      issue(0, 1'b1, 8'd5, 8'd7, 1'b0, 1, mk(8'hFE, 1'b0, 1'b0));
      wait_done(0, "sub_borrow");

      // A start during RUN is ignored; a start on the done cycle is taken at once.
      issue(0, 1'b0, 8'd10, 8'd20, 1'b0, 1, mk(8'd30, 1'b0, 1'b0));
      repeat (2) @(negedge clk);
      check("hold_sum", {24'd0, bus8.sum}, 32'hFE);
      drive(0, 1'b1, 1'b0, 8'd99, 8'd99, 1'b0);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
      wait_done(0, "ignore_mid_run");
      drive(0, 1'b1, 1'b0, 8'd3, 8'd4, 1'b0);
      @(posedge clk);
      #1;
      push(0, '{sum: 8'd7, cout: 1'b0, ovf: 1'b0, cyc: cyc + 32'd8});
      drive(0, 1'b0, 1'b1, 8'hAA, 8'h55, 1'b1);
      wait_done(0, "back_to_back");

      // Abort during the fourth RUN cycle: outputs clear and no done follows.
      issue(0, 1'b0, 8'd10, 8'd20, 1'b0, 0, mk(8'd0, 1'b0, 1'b0));
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("busy_before_abort", {31'd0, bus8.busy}, 32'd1);
      rst = 1'b1;
      #1;
      check("abort_outputs", {21'd0, bus8.busy, bus8.done, bus8.cout, bus8.ovf, bus8.sum}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      issue(0, 1'b0, 8'd100, 8'd27, 1'b1, 1, mk(8'd128, 1'b0, 1'b1));
      wait_done(0, "after_abort");

      // Every operand pair, carry-in and mode on the 4-bit, 2-bit-per-cycle shape.
      for (int sb = 0; sb < 2; sb++)
         for (int ci = 0; ci < 2; ci++)
            for (int a = 0; a < 16; a++)
               for (int b = 0; b < 16; b++) begin
                  issue(1, sb[0], 8'(a), 8'(b), ci[0], 1,
                        model(32'd4, 32'(a), 32'(b), ci[0], sb[0]));
                  wait_done(1, "exhaustive");
               end

      // Single-step shape.
      issue(2, 1'b0, 8'd255, 8'd1, 1'b1, 1, mk(8'd1, 1'b1, 1'b0));
      wait_done(2, "full_width_add");
      issue(2, 1'b1, 8'd0, 8'd1, 1'b0, 1, mk(8'hFF, 1'b0, 1'b0));
      wait_done(2, "full_width_sub");

      repeat (4) @(negedge clk);
      check("scoreboard_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
